// File: rtl/matrix_operand_loader_if.sv
// rtl/matrix_operand_loader_if.sv - element-pair input stream and matrix-pair output bundle
//
// Purpose: groups the input beat handshake and the output matrix handshake of
//          matrix_operand_loader so host, loader and multiplier share one bundle.
// Signals:
//   in_valid / in_ready  : beat handshake, host -> loader
//   a_elem / b_elem      : one element of A and B per beat (ELEM_W bits each)
//   out_valid / out_ready: matrix-pair handshake, loader -> multiplier
//   a_mat / b_mat        : N*N packed elements, row-major, element k at [k*ELEM_W +: ELEM_W]
// Modports:
//   master : host/multiplier view (drives in_* beat and out_ready)
//   slave  : loader view
interface matrix_operand_loader_if #(
    parameter int N      = 2,
    parameter int ELEM_W = 8
);
    logic                    in_valid;
    logic                    in_ready;
    logic [ELEM_W-1:0]       a_elem;
    logic [ELEM_W-1:0]       b_elem;
    logic                    out_valid;
    logic                    out_ready;
    logic [N*N*ELEM_W-1:0]   a_mat;
    logic [N*N*ELEM_W-1:0]   b_mat;

    modport master (
        output in_valid, a_elem, b_elem, out_ready,
        input  in_ready, out_valid, a_mat, b_mat
    );

    modport slave (
        input  in_valid, a_elem, b_elem, out_ready,
        output in_ready, out_valid, a_mat, b_mat
    );
endinterface

// File: rtl/matrix_operand_loader.sv
// rtl/matrix_operand_loader.sv - ping-pong assembler of NxN operand matrix pairs
//
// Purpose: accepts one (A, B) element pair per beat, fills one of two slots in
//          row-major order, and presents each completed pair to the multiplier
//          while the other slot is being refilled.
// Ports:
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low reset
//   ena      : enable for the input side; output side runs regardless
//   clr      : synchronous clear of slots, counter, pointers and overflow
//   bus      : matrix_operand_loader_if.slave (beat input, matrix-pair output)
//   elem_idx : element index the next accepted beat writes
//   overflow : sticky, a beat was offered with ena high while both slots were full
module matrix_operand_loader #(
    parameter int N      = 2,
    parameter int ELEM_W = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ena,
    input  logic                      clr,
    matrix_operand_loader_if.slave    bus,
    output logic [$clog2(N*N)-1:0]    elem_idx,
    output logic                      overflow
);
    localparam int DEPTH = N * N;
    localparam int MAT_W = DEPTH * ELEM_W;
    localparam int IDX_W = $clog2(DEPTH);

    logic [MAT_W-1:0] a_slot_q [2];
    logic [MAT_W-1:0] a_slot_d [2];
    logic [MAT_W-1:0] b_slot_q [2];
    logic [MAT_W-1:0] b_slot_d [2];
    logic [1:0]       full_q, full_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [IDX_W-1:0] elem_idx_q, elem_idx_d;
    logic             overflow_q, overflow_d;

    logic in_ready;
    logic out_valid;
    logic accept;
    logic consume;
    logic last_elem;

    // Handshake outputs depend only on registers plus ena/clr, never on
    // in_valid or out_ready.
    assign in_ready  = ena && !full_q[wr_ptr_q] && !clr;
    assign out_valid = full_q[rd_ptr_q];
    assign accept    = bus.in_valid && in_ready;
    assign consume   = out_valid && bus.out_ready;
    assign last_elem = (elem_idx_q == IDX_W'(DEPTH - 1));

    always_comb begin
        a_slot_d   = a_slot_q;
        b_slot_d   = b_slot_q;
        full_d     = full_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        elem_idx_d = elem_idx_q;
        overflow_d = overflow_q;

        if (clr) begin
            // Slot data is left stale; only the bookkeeping is cleared.
            full_d     = '0;
            wr_ptr_d   = 1'b0;
            rd_ptr_d   = 1'b0;
            elem_idx_d = '0;
            overflow_d = 1'b0;
        end else begin
            if (accept) begin
                for (int k = 0; k < DEPTH; k++) begin
                    if (elem_idx_q == IDX_W'(k)) begin
                        a_slot_d[wr_ptr_q][k*ELEM_W +: ELEM_W] = bus.a_elem;
                        b_slot_d[wr_ptr_q][k*ELEM_W +: ELEM_W] = bus.b_elem;
                    end
                end
                if (last_elem) begin
                    elem_idx_d       = '0;
                    full_d[wr_ptr_q] = 1'b1;
                    wr_ptr_d         = ~wr_ptr_q;
                end else begin
                    elem_idx_d = elem_idx_q + IDX_W'(1);
                end
            end
            // A completing write targets the empty slot while consume clears the
            // full one, so both updates to full_d touch different bits.
            if (consume) begin
                full_d[rd_ptr_q] = 1'b0;
                rd_ptr_d         = ~rd_ptr_q;
            end
            if (bus.in_valid && ena && !in_ready) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < 2; s++) begin
                a_slot_q[s] <= '0;
                b_slot_q[s] <= '0;
            end
            full_q     <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            elem_idx_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            for (int s = 0; s < 2; s++) begin
                a_slot_q[s] <= a_slot_d[s];
                b_slot_q[s] <= b_slot_d[s];
            end
            full_q     <= full_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            elem_idx_q <= elem_idx_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.a_mat     = a_slot_q[rd_ptr_q];
    assign bus.b_mat     = b_slot_q[rd_ptr_q];
    assign elem_idx      = elem_idx_q;
    assign overflow      = overflow_q;
endmodule

// File: tb/tb_matrix_operand_loader.sv
// tb/tb_matrix_operand_loader.sv - scoreboard testbench for matrix_operand_loader
module tb_matrix_operand_loader;
    localparam int N      = 2;
    localparam int ELEM_W = 8;
    localparam int DEPTH  = N * N;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       clr;
    logic [1:0] elem_idx;
    logic       overflow;

    int tests = 0;
    int fails = 0;
    logic [63:0] exp_q [$];

    matrix_operand_loader_if #(.N(N), .ELEM_W(ELEM_W)) bus ();

    matrix_operand_loader #(.N(N), .ELEM_W(ELEM_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .clr      (clr),
        .bus      (bus),
        .elem_idx (elem_idx),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: a pair is consumed on the next rising edge whenever out_valid and
    // out_ready are both high at the falling edge.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_pair", {bus.a_mat, bus.b_mat}, 64'hDEAD_BEEF_DEAD_BEEF);
            end else begin
                check("sb_pair", {bus.a_mat, bus.b_mat}, exp_q.pop_front());
            end
        end
    end

    task automatic beat(input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.a_elem   = a;
        bus.b_elem   = b;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!bus.in_ready) check("beat_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_matrix(input logic [31:0] a, input logic [31:0] b, input bit consume_last);
        exp_q.push_back({a, b});
        for (int k = 0; k < DEPTH; k++) begin
            if (k == DEPTH - 1 && consume_last) bus.out_ready = 1'b1;
            beat(a[k*ELEM_W +: ELEM_W], b[k*ELEM_W +: ELEM_W]);
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic consume_once();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        ena           = 1'b1;
        clr           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a_elem    = '0;
        bus.b_elem    = '0;
        bus.out_ready = 1'b0;
        #12;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_a_mat", bus.a_mat, 0);
        check("rst_b_mat", bus.b_mat, 0);
        check("rst_elem_idx", elem_idx, 0);
        check("rst_overflow", overflow, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single load
        check("single_pre_valid", bus.out_valid, 0);
        send_matrix(32'h04030201, 32'h08070605, 1'b0);
        check("single_out_valid", bus.out_valid, 1);
        check("single_a_mat", bus.a_mat, 32'h04030201);
        check("single_b_mat", bus.b_mat, 32'h08070605);
        check("single_elem_idx", elem_idx, 0);
        consume_once();
        check("single_after_consume", bus.out_valid, 0);

        // Fill both slots, then overflow
        send_matrix(32'h14131211, 32'h18171615, 1'b0);
        check("fill_half_in_ready", bus.in_ready, 1);
        send_matrix(32'h24232221, 32'h28272625, 1'b0);
        check("fill_in_ready", bus.in_ready, 0);
        bus.in_valid = 1'b1;
        bus.a_elem   = 8'h99;
        bus.b_elem   = 8'h99;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("ovf_flag", overflow, 1);
        check("ovf_elem_idx", elem_idx, 0);
        check("ovf_a_unchanged", bus.a_mat, 32'h14131211);
        check("ovf_b_unchanged", bus.b_mat, 32'h18171615);
        consume_once();
        check("ovf_second_valid", bus.out_valid, 1);
        check("ovf_second_a", bus.a_mat, 32'h24232221);
        check("ovf_second_b", bus.b_mat, 32'h28272625);
        check("ovf_in_ready_back", bus.in_ready, 1);
        consume_once();
        check("ovf_drained", bus.out_valid, 0);
        check("ovf_sticky", overflow, 1);

        // Completion of matrix 4 coincides with consume of matrix 3
        send_matrix(32'h34333231, 32'h38373635, 1'b0);
        send_matrix(32'h44434241, 32'h48474645, 1'b1);
        check("simul_out_valid", bus.out_valid, 1);
        check("simul_a_mat", bus.a_mat, 32'h44434241);
        check("simul_b_mat", bus.b_mat, 32'h48474645);
        check("simul_one_slot_free", bus.in_ready, 1);
        consume_once();
        check("simul_drained", bus.out_valid, 0);

        // clr mid-matrix together with a beat
        beat(8'hA1, 8'hB1);
        beat(8'hA2, 8'hB2);
        check("clr_pre_idx", elem_idx, 2);
        bus.in_valid = 1'b1;
        bus.a_elem   = 8'hEE;
        bus.b_elem   = 8'hEE;
        clr          = 1'b1;
        #1;
        check("clr_in_ready_low", bus.in_ready, 0);
        @(posedge clk);
        #1;
        clr          = 1'b0;
        bus.in_valid = 1'b0;
        check("clr_elem_idx", elem_idx, 0);
        check("clr_out_valid", bus.out_valid, 0);
        check("clr_overflow", overflow, 0);
        send_matrix(32'h54535251, 32'h58575655, 1'b0);
        check("clr_reload_a", bus.a_mat, 32'h54535251);
        check("clr_reload_b", bus.b_mat, 32'h58575655);
        consume_once();

        // ena low
        ena          = 1'b0;
        bus.in_valid = 1'b1;
        bus.a_elem   = 8'h55;
        bus.b_elem   = 8'h66;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("ena_low_in_ready", bus.in_ready, 0);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("ena_low_elem_idx", elem_idx, 0);
        check("ena_low_overflow", overflow, 0);
        ena = 1'b1;

        // Async reset mid-beat with one slot full
        send_matrix(32'h64636261, 32'h68676665, 1'b0);
        beat(8'h71, 8'h75);
        beat(8'h72, 8'h76);
        bus.in_valid = 1'b1;
        bus.a_elem   = 8'h73;
        bus.b_elem   = 8'h77;
        #3;
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", bus.out_valid, 0);
        check("arst_a_mat", bus.a_mat, 0);
        check("arst_b_mat", bus.b_mat, 0);
        check("arst_elem_idx", elem_idx, 0);
        check("arst_overflow", overflow, 0);
        check("arst_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;
        send_matrix(32'h04030201, 32'h08070605, 1'b0);
        check("arst_reload_valid", bus.out_valid, 1);
        check("arst_reload_a", bus.a_mat, 32'h04030201);
        check("arst_reload_b", bus.b_mat, 32'h08070605);
        check("arst_reload_idx", elem_idx, 0);
        consume_once();

        repeat (3) @(posedge clk);
        #1;
        check("sb_all_consumed", 64'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/matrix_operand_loader.md
# matrix_operand_loader

Upstream stage of the matrix multiplier. Collects NxN operand matrices A and B one element pair per beat from the dedicated input pins (A) and the bidirectional input pins (B). Assembles them in a two-slot ping-pong buffer and presents complete matrix pairs to the multiplier over a valid/ready handshake. Lets the host stream the next pair while the multiplier consumes the current one.

## Interface
Parameters:
- `N`, 2, matrix dimension; each matrix holds N*N elements.
- `ELEM_W`, 8, element width in bits.

Ports:
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ena` in 1: design enable. While low, input beats are refused; the output side keeps running.
- `clr` in 1: synchronous clear. Empties both slots, zeroes the counter and pointers, and clears `overflow`.
- `in_valid` in 1: host presents an element pair.
- `a_elem` in ELEM_W: element of matrix A (from `ui_in`).
- `b_elem` in ELEM_W: element of matrix B (from `uio_in`).
- `in_ready` out 1: loader accepts a beat. Equals `ena && !full[wr_ptr] && !clr`.
- `out_valid` out 1: the complete pair in the read slot is available. Equals `full[rd_ptr]`.
- `out_ready` in 1: the multiplier takes the pair.
- `a_mat` out N*N*ELEM_W: matrix A from the read slot, row-major; element k at `[k*ELEM_W +: ELEM_W]`.
- `b_mat` out N*N*ELEM_W: matrix B, same packing.
- `elem_idx` out clog2(N*N): index the next accepted beat writes.
- `overflow` out 1: sticky flag. Set when `in_valid && ena && !in_ready && !clr`.

## Operation
- Storage: two slots, each holding A, B and a `full` bit. Pointers: `wr_ptr`, `rd_ptr` (1 bit each). Counter: `elem_idx` (0..N*N-1).
- Accept: on `in_valid && in_ready`, write `a_elem`/`b_elem` into element `elem_idx` of slot `wr_ptr`.
  - If `elem_idx == N*N-1`: reset `elem_idx` to 0, set `full[wr_ptr]`, toggle `wr_ptr`.
  - Otherwise: increment `elem_idx`.
- Consume: on `out_valid && out_ready`, clear `full[rd_ptr]` and toggle `rd_ptr`. Slot data is left stale, not zeroed.
- Simultaneous completion and consume: both take effect in the same cycle. They always target different slots, so no conflict arises.
- Both slots full: `in_ready` = 0. A beat offered with `ena` high sets `overflow` and is discarded; `elem_idx` is unchanged.
- `ena` low: no beats accepted and `overflow` is not set. `out_valid`/consume behaviour is unchanged.
- `clr`: highest priority over accept and consume in the same cycle. Discards any partial matrix and both full slots.
- `a_mat`/`b_mat` are muxed from slot `rd_ptr`. They are meaningful only while `out_valid` = 1 and hold stable until consumed.
- Implicit state per slot: EMPTY (filling or idle) → FULL (last element accepted) → EMPTY (consumed or `clr`).

## Timing
- Reset values: all slot data, `full`, `wr_ptr`, `rd_ptr`, `elem_idx` = 0 and `overflow` = 0. Hence `out_valid` = 0, `a_mat` = `b_mat` = 0, `in_ready` = `ena`.
- Reset mid-operation: immediate asynchronous return to the reset values. A partial matrix is lost.
- Latency: `out_valid` rises in the cycle after the edge that accepts the N*N-th beat, provided that slot is at `rd_ptr`.
- Throughput: one matrix pair per N*N cycles when `out_ready` is held high. No bubbles between matrices.
- `in_ready` and `out_valid` are combinational from registers plus `ena`/`clr`. There is no combinational path from `in_valid` to `in_ready` or from `out_ready` to `out_valid`.
- Capacity: with `out_ready` low, exactly 2*N*N beats are accepted before `in_ready` drops.

## Test plan
- Single load (N=2):
  - Stimulus: beats A = 1,2,3,4 and B = 5,6,7,8, `out_ready` low.
  - Required: `out_valid` = 1 one cycle after the 4th beat; `a_mat` = 0x04030201; `b_mat` = 0x08070605; `elem_idx` back to 0.
- Fill and overflow:
  - Stimulus: 8 beats with `out_ready` = 0, then a 9th beat.
  - Required: `in_ready` = 0 after the 8th beat; the 9th beat sets `overflow` = 1 and slot contents are unchanged.
  - Then pulse `out_ready` once: the first pair is consumed, the second pair appears, and `in_ready` returns to 1.
- Simultaneous completion and consume:
  - Stimulus: the 4th beat of matrix 2 is accepted in the same cycle `out_ready` consumes matrix 1.
  - Required: the next cycle shows `out_valid` = 1 with matrix 2 data, and exactly one slot full.
- `clr` mid-matrix:
  - Stimulus: after 2 beats, assert `clr` together with `in_valid`.
  - Required: the beat is ignored, `elem_idx` = 0, `out_valid` = 0 and `overflow` = 0. A following 4-beat load produces correct data.
- `ena` low:
  - Stimulus: `in_valid` = 1 for 5 cycles with `ena` = 0.
  - Required: `in_ready` = 0, `elem_idx` stays 0 and `overflow` stays 0.
- Async reset:
  - Stimulus: drop `rst_n` mid-cycle during beat 3 with one slot full.
  - Required: all outputs reach their reset values before the next clock edge; a fresh load after release behaves as in the single-load test.
